// File: rtl/fu_mem_lsu.sv
// Load/store functional unit: program-ordered store queue, retirement-gated
// store drain, load ordering check against older stores and a single
// request/grant/response memory port shared by loads and drains.
// Optional build macro: FU_MEM_FWD_EN enables store-to-load forwarding.
module fu_mem_lsu #(
    parameter int XLEN     = 32,
    parameter int SQ_DEPTH = 8,
    parameter int ROB_W    = 5,
    parameter int PREG_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [ROB_W-1:0]  disp_rob,
    output logic              disp_ready,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_is_store,
    input  logic [XLEN-1:0]   issue_base,
    input  logic [XLEN-1:0]   issue_imm,
    input  logic [XLEN-1:0]   issue_wdata,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [ROB_W-1:0]  issue_rob,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              retire_valid,
    input  logic [ROB_W-1:0]  retire_rob,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [PREG_W-1:0] wb_pd,
    output logic [ROB_W-1:0]  wb_rob,
    output logic [XLEN-1:0]   wb_data,
    output logic              store_done,
    output logic [ROB_W-1:0]  store_rob,
    output logic              sq_empty
);
    localparam int IDX_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [XLEN-1:0] WMASK = ~XLEN'(3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3
`ifdef FU_MEM_FWD_EN
        , S_FWD = 3'd4
`endif
    } ld_state_t;

    // Age relative to the ROB head; smaller means older.
    function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] t, input logic [ROB_W-1:0] h);
        return t - h;
    endfunction

    logic [SQ_DEPTH-1:0] vld_q, vld_d, aok_q, aok_d, cmt_q, cmt_d;
    logic [ROB_W-1:0]    sq_rob_q  [SQ_DEPTH];
    logic [XLEN-1:0]     sq_addr_q [SQ_DEPTH];
    logic [XLEN-1:0]     sq_data_q [SQ_DEPTH];
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    ld_state_t           ld_state_q, ld_state_d;
    logic                ld_dead_q, ld_dead_d;
    logic [XLEN-1:0]     ld_addr_q, ld_addr_d;
    logic [PREG_W-1:0]   ld_pd_q, ld_pd_d;
    logic [ROB_W-1:0]    ld_rob_q, ld_rob_d;

    logic                wb_valid_q, wb_valid_d;
    logic [PREG_W-1:0]   wb_pd_q, wb_pd_d;
    logic [ROB_W-1:0]    wb_rob_q, wb_rob_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                store_done_q, store_done_d;
    logic [ROB_W-1:0]    store_rob_q, store_rob_d;

    logic disp_fire, issue_fire, st_fire, ld_fire;
    logic st_hit, ret_hit, ret_seen, fl_seen;
    logic [IDX_W-1:0] st_idx, ret_idx, fl_tail, scan_idx;
    logic [SQ_DEPTH-1:0] fl_mask;
    logic [CNT_W-1:0] fl_n;
    logic ld_req, drain_req, drain_fire, ld_gnt, ld_kill;
    logic chk_unknown, chk_match;
    logic [ROB_W-1:0] match_age;
`ifdef FU_MEM_FWD_EN
    logic [XLEN-1:0] fwd_data;
`endif

    assign disp_ready = (count_q != CNT_W'(SQ_DEPTH));
    // Stores never occupy the load slot, so they are accepted while a load
    // waits on an older store's address.
    assign issue_ready = (ld_state_q == S_IDLE) || issue_is_store;
    assign disp_fire   = disp_valid && disp_ready && !mispredict;
    assign issue_fire  = issue_valid && issue_ready && !mispredict;
    assign st_fire     = issue_fire && issue_is_store;
    assign ld_fire     = issue_fire && !issue_is_store;
    assign sq_empty    = (count_q == '0);

    // Memory port arbitration: a load in REQ wins over a committed-head drain.
    assign ld_req     = (ld_state_q == S_REQ);
    assign drain_req  = vld_q[head_q] && cmt_q[head_q] && !ld_req;
    assign ld_gnt     = ld_req && mem_gnt;
    assign drain_fire = drain_req && mem_gnt;
    assign mem_req    = ld_req || drain_req;
    assign mem_we     = drain_req;
    assign mem_addr   = ld_req ? (ld_addr_q & WMASK) : drain_req ? (sq_addr_q[head_q] & WMASK) : '0;
    assign mem_wdata  = drain_req ? sq_data_q[head_q] : '0;

    assign ld_kill = mispredict && (ld_state_q != S_IDLE) &&
                     (age_of(ld_rob_q, rob_head) > age_of(mispredict_tag, rob_head));

    // Store-queue lookups: issue match, oldest uncommitted entry, flush set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        st_hit = 1'b0; st_idx = '0;
        ret_seen = 1'b0; ret_hit = 1'b0; ret_idx = '0;
        fl_mask = '0; fl_seen = 1'b0; fl_tail = tail_q; fl_n = '0; scan_idx = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (vld_q[i] && sq_rob_q[i] == issue_rob) begin
                st_hit = 1'b1;
                st_idx = IDX_W'(i);
            end
        end
        for (int k = 0; k < SQ_DEPTH; k++) begin
            scan_idx = head_q + IDX_W'(k);
            if (!ret_seen && vld_q[scan_idx] && !cmt_q[scan_idx]) begin
                ret_seen = 1'b1;
                ret_idx  = scan_idx;
                ret_hit  = retire_valid && (sq_rob_q[scan_idx] == retire_rob);
            end
        end
        for (int i = 0; i < SQ_DEPTH; i++) begin
            fl_mask[i] = mispredict && vld_q[i] && !cmt_q[i] &&
                         !(ret_hit && ret_idx == IDX_W'(i)) &&
                         (age_of(sq_rob_q[i], rob_head) > age_of(mispredict_tag, rob_head));
        end
        for (int k = 0; k < SQ_DEPTH; k++) begin
            scan_idx = head_q + IDX_W'(k);
            if (fl_mask[scan_idx]) begin
                fl_n = fl_n + CNT_W'(1);
                if (!fl_seen) begin
                    fl_seen = 1'b1;
                    fl_tail = scan_idx;
                end
            end
        end
    end

    // Ordering check of the pending load against older stores.
    always_comb begin
        chk_unknown = 1'b0; chk_match = 1'b0; match_age = '0;
`ifdef FU_MEM_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (vld_q[i] && age_of(sq_rob_q[i], rob_head) < age_of(ld_rob_q, rob_head)) begin
                if (!aok_q[i]) begin
                    chk_unknown = 1'b1;
                end else if ((sq_addr_q[i] & WMASK) == (ld_addr_q & WMASK) &&
                             (!chk_match || age_of(sq_rob_q[i], rob_head) > match_age)) begin
                    chk_match = 1'b1;
                    match_age = age_of(sq_rob_q[i], rob_head);
`ifdef FU_MEM_FWD_EN
                    fwd_data  = sq_data_q[i];
`endif
                end
            end
        end
    end

    // Store-queue control next state: allocate, address fill, commit, drain, flush.
    always_comb begin
        vld_d = vld_q; aok_d = aok_q; cmt_d = cmt_q;
        head_d = head_q; tail_d = tail_q;
        store_done_d = st_fire && st_hit;
        store_rob_d  = (st_fire && st_hit) ? issue_rob : store_rob_q;
        if (disp_fire) begin
            vld_d[tail_q] = 1'b1;
            aok_d[tail_q] = 1'b0;
            cmt_d[tail_q] = 1'b0;
            tail_d        = tail_q + IDX_W'(1);
        end
        if (st_fire && st_hit) aok_d[st_idx] = 1'b1;
        if (ret_hit) cmt_d[ret_idx] = 1'b1;
        if (drain_fire) begin
            vld_d[head_q] = 1'b0;
            cmt_d[head_q] = 1'b0;
            head_d        = head_q + IDX_W'(1);
        end
        vld_d = vld_d & ~fl_mask;
        if (fl_seen) tail_d = fl_tail;
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(drain_fire) - fl_n;
    end

    // Load FSM next state and writeback generation.
    always_comb begin
        ld_state_d = ld_state_q; ld_dead_d = ld_dead_q;
        ld_addr_d = ld_addr_q; ld_pd_d = ld_pd_q; ld_rob_d = ld_rob_q;
        wb_valid_d = 1'b0; wb_pd_d = wb_pd_q; wb_rob_d = wb_rob_q; wb_data_d = wb_data_q;
        case (ld_state_q)
            S_IDLE: if (ld_fire) begin
                ld_state_d = S_CHECK;
                ld_dead_d  = 1'b0;
                ld_addr_d  = issue_base + issue_imm;
                ld_pd_d    = issue_pd;
                ld_rob_d   = issue_rob;
            end
            S_CHECK: if (!chk_unknown) begin
                if (chk_match) begin
`ifdef FU_MEM_FWD_EN
                    ld_state_d = S_FWD;
                    wb_valid_d = 1'b1;
                    wb_pd_d    = ld_pd_q;
                    wb_rob_d   = ld_rob_q;
                    wb_data_d  = fwd_data;
`endif
                end else begin
                    ld_state_d = S_REQ;
                end
            end
`ifdef FU_MEM_FWD_EN
            S_FWD: ld_state_d = S_IDLE;
`endif
            S_REQ: if (ld_gnt) ld_state_d = S_WAIT;
            S_WAIT: if (mem_rvalid) begin
                ld_state_d = S_IDLE;
                wb_valid_d = !ld_dead_q;
                if (!ld_dead_q) begin
                    wb_pd_d   = ld_pd_q;
                    wb_rob_d  = ld_rob_q;
                    wb_data_d = mem_rdata;
                end
            end
            default: ld_state_d = S_IDLE;
        endcase
        // A killed load with a read in flight must sink that response.
        if (ld_kill) begin
            wb_valid_d = 1'b0;
            if ((ld_state_q == S_WAIT && !mem_rvalid) || ld_gnt) begin
                ld_state_d = S_WAIT;
                ld_dead_d  = 1'b1;
            end else begin
                ld_state_d = S_IDLE;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0; aok_q <= '0; cmt_q <= '0;
            head_q <= '0; tail_q <= '0; count_q <= '0;
            ld_state_q <= S_IDLE; ld_dead_q <= 1'b0;
            ld_addr_q <= '0; ld_pd_q <= '0; ld_rob_q <= '0;
            wb_valid_q <= 1'b0; wb_pd_q <= '0; wb_rob_q <= '0; wb_data_q <= '0;
            store_done_q <= 1'b0; store_rob_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            vld_q <= vld_d; aok_q <= aok_d; cmt_q <= cmt_d;
            head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            ld_state_q <= ld_state_d; ld_dead_q <= ld_dead_d;
            ld_addr_q <= ld_addr_d; ld_pd_q <= ld_pd_d; ld_rob_q <= ld_rob_d;
            wb_valid_q <= wb_valid_d; wb_pd_q <= wb_pd_d; wb_rob_q <= wb_rob_d; wb_data_q <= wb_data_d;
            store_done_q <= store_done_d; store_rob_q <= store_rob_d;
        end
    end

    // Entry payload storage, written on allocate and on store issue.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; every read is qualified by a reset valid bit.
        if (disp_fire) sq_rob_q[tail_q] <= disp_rob;
        if (st_fire && st_hit) begin
            sq_addr_q[st_idx] <= issue_base + issue_imm;
            sq_data_q[st_idx] <= issue_wdata;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_pd      = wb_pd_q;
    assign wb_rob     = wb_rob_q;
    assign wb_data    = wb_data_q;
    assign store_done = store_done_q;
    assign store_rob  = store_rob_q;
endmodule

// File: tb/tb_fu_mem_lsu.sv
// Scoreboard bench for fu_mem_lsu: stimulus pushes expected writebacks,
// store completions and memory writes; a monitor pops and compares them.
module tb_fu_mem_lsu;
    localparam int XLEN = 32, SQ_DEPTH = 8, ROB_W = 5, PREG_W = 7;

    logic clk, reset;
    logic disp_valid, disp_ready, issue_valid, issue_ready, issue_is_store;
    logic [ROB_W-1:0] disp_rob, issue_rob, rob_head, retire_rob, mispredict_tag;
    logic [XLEN-1:0] issue_base, issue_imm, issue_wdata;
    logic [PREG_W-1:0] issue_pd;
    logic retire_valid, mispredict;
    logic mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic wb_valid, store_done, sq_empty;
    logic [PREG_W-1:0] wb_pd;
    logic [ROB_W-1:0] wb_rob, store_rob;
    logic [XLEN-1:0] wb_data;
    logic gnt_en;
    int   rd_lat, cyc;

    fu_mem_lsu #(.XLEN(XLEN), .SQ_DEPTH(SQ_DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_rob(disp_rob), .disp_ready(disp_ready),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_store(issue_is_store),
        .issue_base(issue_base), .issue_imm(issue_imm), .issue_wdata(issue_wdata),
        .issue_pd(issue_pd), .issue_rob(issue_rob), .rob_head(rob_head),
        .retire_valid(retire_valid), .retire_rob(retire_rob),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_rob(wb_rob), .wb_data(wb_data),
        .store_done(store_done), .store_rob(store_rob), .sq_empty(sq_empty)
    );

    assign mem_gnt = mem_req & gnt_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [PREG_W-1:0] pd; logic [ROB_W-1:0] rob; logic [XLEN-1:0] data; } wb_t;
    typedef struct packed { logic [XLEN-1:0] addr; logic [XLEN-1:0] data; } wr_t;
    typedef struct { int due; logic [XLEN-1:0] data; } rd_t;
    wb_t exp_wb[$];
    logic [ROB_W-1:0] exp_sd[$];
    wr_t exp_wr[$];
    rd_t rd_pend[$];
    logic [XLEN-1:0] mem [logic [XLEN-1:0]];

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    function automatic logic [XLEN-1:0] rd_val(input logic [XLEN-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // Memory responder: grant follows gnt_en, reads answer rd_lat cycles later.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            if (rd_pend.size() != 0 && rd_pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_pend[0].data;
                void'(rd_pend.pop_front());
            end
            if (mem_req && mem_gnt) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else rd_pend.push_back('{cyc + rd_lat, rd_val(mem_addr)});
            end
        end
    end

    // Monitor: compare every DUT event against the scoreboard queues.
    initial begin
        wb_t e;
        wr_t w;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (exp_wb.size() == 0) fail_now("wb_unexpected", {wb_rob, wb_data});
                else begin
                    e = exp_wb.pop_front();
                    check("wb_pd", wb_pd, e.pd);
                    check("wb_rob", wb_rob, e.rob);
                    check("wb_data", wb_data, e.data);
                end
            end
            if (store_done) begin
                if (exp_sd.size() == 0) fail_now("store_done_unexpected", store_rob);
                else check("store_rob", store_rob, exp_sd.pop_front());
            end
            if (mem_req && mem_gnt && mem_we) begin
                if (exp_wr.size() == 0) fail_now("mem_write_unexpected", mem_addr);
                else begin
                    w = exp_wr.pop_front();
                    check("mem_waddr", mem_addr, w.addr);
                    check("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dispatch(input logic [ROB_W-1:0] rob);
        disp_valid = 1'b1; disp_rob = rob;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic issue_store(input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] base,
                               input logic [XLEN-1:0] imm, input logic [XLEN-1:0] data);
        exp_sd.push_back(rob);
        issue_valid = 1'b1; issue_is_store = 1'b1; issue_rob = rob;
        issue_base = base; issue_imm = imm; issue_wdata = data;
        step();
        issue_valid = 1'b0; issue_is_store = 1'b0;
    endtask

    task automatic issue_load(input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] pd,
                              input logic [XLEN-1:0] base, input logic [XLEN-1:0] imm);
        issue_valid = 1'b1; issue_is_store = 1'b0; issue_rob = rob; issue_pd = pd;
        issue_base = base; issue_imm = imm;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic retire(input logic [ROB_W-1:0] rob);
        retire_valid = 1'b1; retire_rob = rob;
        step();
        retire_valid = 1'b0;
    endtask

    task automatic settle(input string name);
        int k;
        k = 0;
        while ((exp_wb.size() != 0 || exp_sd.size() != 0 || exp_wr.size() != 0 ||
                rd_pend.size() != 0 || issue_ready !== 1'b1) && k < 200) begin
            step();
            k++;
        end
        step();
        check({"settle_", name}, (k >= 200), 0);
    endtask

    initial begin
        reset = 1'b1; gnt_en = 1'b0; rd_lat = 2;
        disp_valid = 0; disp_rob = 0; issue_valid = 0; issue_is_store = 0;
        issue_base = 0; issue_imm = 0; issue_wdata = 0; issue_pd = 0; issue_rob = 0;
        rob_head = 0; retire_valid = 0; retire_rob = 0; mispredict = 0; mispredict_tag = 0;
        step(2);
        reset = 1'b0;
        step();
        check("rst_sq_empty", sq_empty, 1);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_store_done", store_done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_data", wb_data, 0);

        // Store lifecycle.
        dispatch(3);
        check("life_sq_nonempty", sq_empty, 0);
        issue_store(3, 32'h100, 32'h4, 32'hDEADBEEF);
        check("life_store_done", store_done, 1);
        check("life_store_rob", store_rob, 3);
        check("life_no_drain_before_retire", mem_req, 0);
        retire(3);
        check("life_mem_req", mem_req, 1);
        check("life_mem_we", mem_we, 1);
        check("life_mem_addr", mem_addr, 32'h104);
        check("life_mem_wdata", mem_wdata, 32'hDEADBEEF);
        exp_wr.push_back('{32'h104, 32'hDEADBEEF});
        gnt_en = 1'b1;
        step();
        check("life_sq_empty_after_drain", sq_empty, 1);

        // Same-address store then load: forward, or wait for the drain.
        mem[32'h40] = 32'hAAAA5555;
        dispatch(2);
        issue_store(2, 32'h40, 32'h0, 32'h11);
        exp_wb.push_back('{7'd9, 5'd4, 32'h11});
        issue_load(4, 9, 32'h3C, 32'h4);
`ifdef FU_MEM_FWD_EN
        step();
        check("fwd_wb_two_cycles", wb_valid, 1);
        check("fwd_no_mem_req", mem_req, 0);
`else
        for (int i = 0; i < 4; i++) begin
            check("nofwd_wb_held", wb_valid, 0);
            check("nofwd_no_mem_req", mem_req, 0);
            step();
        end
`endif
        exp_wr.push_back('{32'h40, 32'h11});
        retire(2);
        settle("fwd");

        // Older store with unknown address blocks the load.
        mem[32'h200] = 32'h5555;
        dispatch(1);
        exp_wb.push_back('{7'd5, 5'd2, 32'h5555});
        issue_load(2, 5, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("unk_no_mem_req", mem_req, 0);
            check("unk_slot_busy", issue_ready, 0);
            step();
        end
        issue_store(1, 32'h300, 32'h0, 32'h77);
        settle("unk_load");
        exp_wr.push_back('{32'h300, 32'h77});
        retire(1);
        settle("unk_drain");
        check("unk_sq_empty", sq_empty, 1);

        // Reset while a load waits for its response.
        rd_lat = 4;
        mem[32'h800] = 32'h1234;
        dispatch(3);
        issue_load(1, 2, 32'h800, 32'h0);
        step(2);
        check("rstw_in_wait", issue_ready, 0);
        reset = 1'b1;
        #2;
        check("rstw_sq_empty", sq_empty, 1);
        check("rstw_disp_ready", disp_ready, 1);
        check("rstw_issue_ready", issue_ready, 1);
        check("rstw_wb_valid", wb_valid, 0);
        check("rstw_mem_req", mem_req, 0);
        step();
        reset = 1'b0;
        step(6);
        check("rstw_sq_empty_after", sq_empty, 1);

        // Fill, drain one, wrap the tail.
        rd_lat = 2;
        for (int i = 0; i < SQ_DEPTH; i++) dispatch(5'(10 + i));
        check("full_disp_ready", disp_ready, 0);
        dispatch(30);
        issue_store(10, 32'h1000, 32'h0, 32'hA0);
        exp_wr.push_back('{32'h1000, 32'hA0});
        retire(10);
        step();
        check("full_drain_one_ready", disp_ready, 1);
        dispatch(18);
        check("wrap_full_again", disp_ready, 0);
        for (int i = 11; i <= 18; i++) begin
            issue_store(5'(i), 32'h1000 + 32'(4 * (i - 10)), 32'h0, 32'hA0 + 32'(i - 10));
            exp_wr.push_back('{32'h1000 + 32'(4 * (i - 10)), 32'hA0 + 32'(i - 10)});
            retire(5'(i));
        end
        settle("wrap");
        check("wrap_sq_empty", sq_empty, 1);

        // Mispredict flushes younger stores and kills the waiting load.
        rob_head = 4; rd_lat = 6;
        mem[32'h500] = 32'hBAD;
        dispatch(5); dispatch(6); dispatch(7);
        issue_store(5, 32'h600, 32'h0, 32'h55);
        issue_store(6, 32'h604, 32'h0, 32'h66);
        issue_store(7, 32'h608, 32'h0, 32'h77);
        issue_load(8, 3, 32'h500, 32'h0);
        step(2);
        check("mp_load_waiting", issue_ready, 0);
        mispredict = 1'b1; mispredict_tag = 5; disp_valid = 1'b1; disp_rob = 20;
        step();
        mispredict = 1'b0; disp_valid = 1'b0;
        check("mp_sq_nonempty", sq_empty, 0);
        check("mp_load_sinking", issue_ready, 0);
        dispatch(9);
        issue_store(9, 32'h700, 32'h0, 32'h99);
        exp_wr.push_back('{32'h600, 32'h55});
        exp_wr.push_back('{32'h700, 32'h99});
        retire(5);
        retire(9);
        settle("mp");
        check("mp_sq_empty", sq_empty, 1);
        check("mp_issue_ready", issue_ready, 1);

        check("sb_wb_left", exp_wb.size(), 0);
        check("sb_sd_left", exp_sd.size(), 0);
        check("sb_wr_left", exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fu_mem_lsu.md
Name: fu_mem_lsu

Overview:
Parametrised load/store functional unit for the OoO core. It holds a program-ordered store queue (SQ) of SQ_DEPTH entries allocated at dispatch and filled at issue. Stores drain to memory only after ROB retirement. Loads are checked against older stores, with optional forwarding. The block drives an external request/grant/response memory port and writes load results back to the PRF/ROB.

Parameters:
XLEN, 32, data/address width
SQ_DEPTH, 8, store queue entries (power of 2, >=2)
ROB_W, 5, ROB tag width
PREG_W, 7, physical register tag width

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
disp_valid  in  1  allocate SQ entry for a dispatched store
disp_rob  in  ROB_W  ROB tag of that store
disp_ready  out  1  SQ not full
issue_valid  in  1  RS issues a memory op
issue_ready  out  1  unit accepts issue
issue_is_store  in  1  1=SW, 0=LW
issue_base  in  XLEN  ps1 data
issue_imm  in  XLEN  sign-extended immediate
issue_wdata  in  XLEN  ps2 data (stores)
issue_pd  in  PREG_W  load destination
issue_rob  in  ROB_W  ROB tag
rob_head  in  ROB_W  oldest ROB tag (age reference)
retire_valid  in  1  ROB retires an instruction
retire_rob  in  ROB_W  retired tag
mispredict  in  1  flush request
mispredict_tag  in  ROB_W  branch tag; strictly younger ops flushed
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  XLEN  word address (bits [1:0] forced 0)
mem_wdata  out  XLEN  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data
wb_valid  out  1  load result pulse
wb_pd  out  PREG_W  destination
wb_rob  out  ROB_W  ROB tag
wb_data  out  XLEN  loaded word
store_done  out  1  store address/data captured pulse
store_rob  out  ROB_W  tag of completed store
sq_empty  out  1  no valid SQ entries

Behaviour:
- Reset (async): SQ head/tail/count 0; all entries invalid; load slot empty. Outputs: wb_valid=0, store_done=0, mem_req=0, sq_empty=1, disp_ready=1, issue_ready=1. All data/tag outputs 0.
- Age: age(t) = (t - rob_head) mod 2^ROB_W. Older = smaller age.
- Dispatch: if disp_valid && disp_ready, entry[tail] <= {valid=1, rob=disp_rob, addr_ok=0, committed=0}; tail++ with wrap. disp_ready = count != SQ_DEPTH.
- issue_ready = load slot empty. The handshake is issue_valid && issue_ready.
- Store issue: find the valid entry with rob==issue_rob. Write addr=issue_base+issue_imm and data, set addr_ok=1. Next cycle store_done=1 with store_rob=issue_rob, for one cycle. If no entry matches, the op is dropped and store_done stays 0.
- Retire: if retire_valid and retire_rob matches the oldest uncommitted valid entry, set committed=1. Otherwise ignore.
- Load issue: capture addr/pd/rob into the load slot; the slot becomes busy. Each cycle while in state CHECK, scan SQ entries older than the load:
  - any older entry with addr_ok=0 -> stay in CHECK (retry next cycle);
  - else if the youngest older entry has a matching addr[XLEN-1:2] -> forward (see FU_MEM_FWD_EN);
  - else -> state REQ.
- Load FSM: IDLE -> CHECK -> (FWD | REQ) -> WAIT -> IDLE.
  - FWD: wb_valid next cycle with entry data; return to IDLE.
  - REQ: mem_req=1, mem_we=0 until mem_gnt; then go to WAIT.
  - WAIT: on mem_rvalid, wb_valid=1 with wb_data=mem_rdata; return to IDLE.
  - Earliest load latency (forward) is 2 cycles from issue.
- Store drain: when the head entry is committed and the load FSM is not in REQ, drive mem_req=1, mem_we=1 with head addr/data. On mem_gnt, invalidate head, head++. Loads in REQ take port priority over drains.
- count updates correctly on simultaneous alloc and drain (net unchanged).
- Mispredict (same cycle):
  - invalidate every valid, uncommitted entry with age(rob) > age(mispredict_tag); set tail to the lowest-age flushed index;
  - if the load slot is busy and age(load rob) > age(mispredict_tag), kill it. A killed load in WAIT sinks its pending mem_rvalid without wb_valid; otherwise it goes IDLE immediately;
  - dispatch and issue are ignored in the mispredict cycle;
  - committed entries are never flushed.
- Reset mid-operation: all state cleared, and any outstanding memory response is ignored.
- sq_empty = (count==0).

Optional Feature:
FU_MEM_FWD_EN. Defined: a matching youngest-older store forwards its data (FWD state) without a memory access. Undefined: the load stays in CHECK until the matching store has drained (its entry is invalid). After that the load takes the REQ path. The FWD state is not built.

Test Plan:
- Reset: assert reset mid-WAIT -> sq_empty=1, disp_ready=1, issue_ready=1, wb_valid=0; a late mem_rvalid produces no writeback.
- Store lifecycle: dispatch rob 3; issue SW base 0x100 imm 4 data 0xDEADBEEF -> store_done, store_rob=3 next cycle. Retire 3 -> mem_req, mem_we=1, addr 0x104, data 0xDEADBEEF; on gnt, sq_empty=1.
- Forwarding (FWD_EN): store rob 2 to 0x40 data 0x11, load rob 4 from 0x40 -> wb_data=0x11, wb_rob=4 two cycles after issue, no mem_req. Without macro: no wb until the store drains, then mem read path.
- Unknown older address: dispatch store rob 1 (not issued); issue load rob 2 -> stays in CHECK with no mem_req. Issue store rob 1 to a different address -> load proceeds to REQ.
- Full/wrap: SQ_DEPTH allocations -> disp_ready=0. Drain one -> disp_ready=1. Allocate again -> tail wraps to index 0.
- Mispredict: entries rob 5,6,7 uncommitted, rob_head 4, mispredict_tag 5, load rob 8 in WAIT -> entries 6,7 invalid, tail points to 6's slot, and the load response is dropped (no wb_valid).
